simon2share_core: RTL and testbench



---
 rtl/simon_pkg.sv | 43 ++++
 rtl/simon_round_2share.sv | 51 +++++
 rtl/simon2share_core.sv | 178 +++++++++++++++++
 tb/tb_simon2share_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared constants, state encoding and rotate helpers for the 2-share SIMON-128/128 core.
package simon_pkg;

    localparam int N_ROUNDS = 68;
    localparam int WORD     = 64;

    localparam logic [WORD-1:0] C  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [61:0]     Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [WORD-1:0] rol1(input logic [WORD-1:0] v);
        return {v[62:0], v[63]};
    endfunction

    function automatic logic [WORD-1:0] rol2(input logic [WORD-1:0] v);
        return {v[61:0], v[63:62]};
    endfunction

    function automatic logic [WORD-1:0] rol8(input logic [WORD-1:0] v);
        return {v[55:0], v[63:56]};
    endfunction

    function automatic logic [WORD-1:0] ror1(input logic [WORD-1:0] v);
        return {v[0], v[63:1]};
    endfunction

    function automatic logic [WORD-1:0] ror3(input logic [WORD-1:0] v);
        return {v[2:0], v[63:3]};
    endfunction

    // z2 is stored MSB-first, so sequence element i lives at bit 61-i.
    function automatic logic z2_bit(input logic [6:0] rnd);
        logic [5:0] idx;
        idx = (rnd >= 7'd62) ? 6'(rnd - 7'd62) : rnd[5:0];
        return Z2[6'd61 - idx];
    endfunction

endpackage

// File: rtl/simon_round_2share.sv
// One masked SIMON round plus one key-schedule step, computed for both shares.
module simon_round_2share
    import simon_pkg::*;
(
    input  logic [WORD-1:0] x_a,
    input  logic [WORD-1:0] y_a,
    input  logic [WORD-1:0] x_b,
    input  logic [WORD-1:0] y_b,
    input  logic [WORD-1:0] k0_a,
    input  logic [WORD-1:0] k1_a,
    input  logic [WORD-1:0] k0_b,
    input  logic [WORD-1:0] k1_b,
    input  logic [6:0]      rnd,
    output logic [WORD-1:0] x_a_nxt,
    output logic [WORD-1:0] y_a_nxt,
    output logic [WORD-1:0] x_b_nxt,
    output logic [WORD-1:0] y_b_nxt,
    output logic [WORD-1:0] k2_a,
    output logic [WORD-1:0] k2_b
);

    logic [WORD-1:0] s1_a_s, s2_a_s, s8_a_s;
    logic [WORD-1:0] s1_b_s, s2_b_s, s8_b_s;
    logic [WORD-1:0] f_a_s, f_b_s;
    logic [WORD-1:0] t_a_s, t_b_s;
    logic [WORD-1:0] rc_s;

    assign s1_a_s = rol1(x_a);
    assign s2_a_s = rol2(x_a);
    assign s8_a_s = rol8(x_a);
    assign s1_b_s = rol1(x_b);
    assign s2_b_s = rol2(x_b);
    assign s8_b_s = rol8(x_b);

    // Cross-share AND terms: the two f shares XOR to (S1 x)&(S8 x) ^ S2 x.
    assign f_a_s = (s1_a_s & s8_a_s) ^ (s1_a_s & s8_b_s) ^ s2_a_s;
    assign f_b_s = (s1_b_s & s8_b_s) ^ (s1_b_s & s8_a_s) ^ s2_b_s;

    assign x_a_nxt = y_a ^ f_a_s ^ k0_a;
    assign y_a_nxt = x_a;
    assign x_b_nxt = y_b ^ f_b_s ^ k0_b;
    assign y_b_nxt = x_b;

    // Key schedule is linear, so the round constant goes into share A only.
    assign t_a_s = ror3(k1_a);
    assign t_b_s = ror3(k1_b);
    assign rc_s  = C ^ {{(WORD-1){1'b0}}, z2_bit(rnd)};
    assign k2_a  = k0_a ^ t_a_s ^ ror1(t_a_s) ^ rc_s;
    assign k2_b  = k0_b ^ t_b_s ^ ror1(t_b_s);

endmodule

// File: rtl/simon2share_core.sv
// Round-based 2-share masked SIMON-128/128 encryption core with serial share loading.
// Define SIMON2SHARE_SHARE_OUT_EN to expose the raw final shares on cipher_out_a/cipher_out_b.
module simon2share_core
    import simon_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         data_ina,
    input  logic         data_inb,
    input  logic [1:0]   data_rdy,
    output logic [127:0] cipher_out,
    output logic         Done,
    output logic         Trig
`ifdef SIMON2SHARE_SHARE_OUT_EN
    ,
    output logic [127:0] cipher_out_a,
    output logic [127:0] cipher_out_b
`endif
);

    state_e          state_r, state_nxt_s;
    logic [6:0]      rnd_r;
    logic [127:0]    key_a_r, key_b_r, pt_a_r, pt_b_r;
    logic [WORD-1:0] x_a_r, y_a_r, x_b_r, y_b_r;
    logic [WORD-1:0] k0_a_r, k1_a_r, k0_b_r, k1_b_r;
    logic [WORD-1:0] x_a_s, y_a_s, x_b_s, y_b_s, k2_a_s, k2_b_s;
    logic [127:0]    cipher_r;
    logic            done_r, trig_r;
    logic            loadable_s, load_key_s, load_pt_s, start_s, last_round_s;

    assign loadable_s   = (state_r == IDLE) || (state_r == DONE);
    assign load_key_s   = loadable_s && (data_rdy == 2'b10);
    assign load_pt_s    = loadable_s && (data_rdy == 2'b01);
    assign start_s      = (state_r == IDLE) && (data_rdy == 2'b11);
    assign last_round_s = (state_r == RUN) && (rnd_r == 7'(N_ROUNDS - 1));

    simon_round_2share u_round (
        .x_a     (x_a_r),
        .y_a     (y_a_r),
        .x_b     (x_b_r),
        .y_b     (y_b_r),
        .k0_a    (k0_a_r),
        .k1_a    (k1_a_r),
        .k0_b    (k0_b_r),
        .k1_b    (k1_b_r),
        .rnd     (rnd_r),
        .x_a_nxt (x_a_s),
        .y_a_nxt (y_a_s),
        .x_b_nxt (x_b_s),
        .y_b_nxt (y_b_s),
        .k2_a    (k2_a_s),
        .k2_b    (k2_b_s)
    );

    // Next-state logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_nxt_s = RUN;
                else         state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_round_s) state_nxt_s = DONE;
                else              state_nxt_s = RUN;
            end
            DONE: begin
                if (load_key_s || load_pt_s) state_nxt_s = IDLE;
                else                         state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Serial share loaders; bit i of the stream ends at register bit i.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_a_r <= 128'd0;
            key_b_r <= 128'd0;
            pt_a_r  <= 128'd0;
            pt_b_r  <= 128'd0;
        end else begin
            if (load_key_s) begin
                key_a_r <= {data_ina, key_a_r[127:1]};
                key_b_r <= {data_inb, key_b_r[127:1]};
            end
            if (load_pt_s) begin
                pt_a_r <= {data_ina, pt_a_r[127:1]};
                pt_b_r <= {data_inb, pt_b_r[127:1]};
            end
        end
    end

    // Masked state and round-key pipeline, one round per clock in RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_a_r  <= 64'd0;
            y_a_r  <= 64'd0;
            x_b_r  <= 64'd0;
            y_b_r  <= 64'd0;
            k0_a_r <= 64'd0;
            k1_a_r <= 64'd0;
            k0_b_r <= 64'd0;
            k1_b_r <= 64'd0;
            rnd_r  <= 7'd0;
        end else if (start_s) begin
            x_a_r  <= pt_a_r[127:64];
            y_a_r  <= pt_a_r[63:0];
            x_b_r  <= pt_b_r[127:64];
            y_b_r  <= pt_b_r[63:0];
            k0_a_r <= key_a_r[63:0];
            k1_a_r <= key_a_r[127:64];
            k0_b_r <= key_b_r[63:0];
            k1_b_r <= key_b_r[127:64];
            rnd_r  <= 7'd0;
        end else if (state_r == RUN) begin
            x_a_r  <= x_a_s;
            y_a_r  <= y_a_s;
            x_b_r  <= x_b_s;
            y_b_r  <= y_b_s;
            k0_a_r <= k1_a_r;
            k1_a_r <= k2_a_s;
            k0_b_r <= k1_b_r;
            k1_b_r <= k2_b_s;
            rnd_r  <= rnd_r + 7'd1;
        end
    end

    // Registered result, Done flag and single-cycle trigger.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cipher_r <= 128'd0;
            done_r   <= 1'b0;
            trig_r   <= 1'b0;
        end else begin
            trig_r <= start_s;
            if (last_round_s) begin
                cipher_r <= {x_a_s ^ x_b_s, y_a_s ^ y_b_s};
                done_r   <= 1'b1;
            end else if (state_r == DONE && (load_key_s || load_pt_s)) begin
                cipher_r <= 128'd0;
                done_r   <= 1'b0;
            end
        end
    end

    assign cipher_out = cipher_r;
    assign Done       = done_r;
    assign Trig       = trig_r;

`ifdef SIMON2SHARE_SHARE_OUT_EN
    logic [127:0] share_a_r, share_b_r;

    // Raw final shares, held alongside the recombined result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            share_a_r <= 128'd0;
            share_b_r <= 128'd0;
        end else if (last_round_s) begin
            share_a_r <= {x_a_s, y_a_s};
            share_b_r <= {x_b_s, y_b_s};
        end else if (state_r == DONE && (load_key_s || load_pt_s)) begin
            share_a_r <= 128'd0;
            share_b_r <= 128'd0;
        end
    end

    assign cipher_out_a = share_a_r;
    assign cipher_out_b = share_b_r;
`endif

endmodule

// File: tb/tb_simon2share_core.sv
// Scoreboard bench for simon2share_core: loads shares serially, runs encryptions, checks results and timing.
module tb_simon2share_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         data_ina, data_inb;
    logic [1:0]   data_rdy;
    logic [127:0] cipher_out;
    logic         Done, Trig;
`ifdef SIMON2SHARE_SHARE_OUT_EN
    logic [127:0] cipher_out_a, cipher_out_b;
`endif

    int checks   = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

    localparam logic [255:0] STD_VEC = 256'h0f0e0d0c0b0a0908070605040302010063736564207372656c6c657661727420;
    localparam logic [255:0] STD_SB  = 256'h4984135146514455468484448764456412346845131555465757486435446838;
    localparam logic [127:0] STD_CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

    simon2share_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_ina   (data_ina),
        .data_inb   (data_inb),
        .data_rdy   (data_rdy),
        .cipher_out (cipher_out),
        .Done       (Done),
        .Trig       (Trig)
`ifdef SIMON2SHARE_SHARE_OUT_EN
        ,
        .cipher_out_a (cipher_out_a),
        .cipher_out_b (cipher_out_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rl(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Plain unmasked SIMON-128/128 reference.
    function automatic logic [127:0] simon_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [61:0] z;
        logic [63:0] x, y, k0, k1, k2, t, tmp;
        z  = 62'b10101111011100000011010010011000101000010001111110010110110011;
        x  = pt[127:64];
        y  = pt[63:0];
        k0 = key[63:0];
        k1 = key[127:64];
        for (int r = 0; r < 68; r++) begin
            tmp = x;
            x   = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ k0;
            y   = tmp;
            t   = rr(k1, 3);
            t   = t ^ rr(t, 1);
            k2  = ~k0 ^ t ^ {63'd0, z[61 - (r % 62)]} ^ 64'd3;
            k0  = k1;
            k1  = k2;
        end
        return {x, y};
    endfunction

    task automatic load_shares(input logic [127:0] ka, input logic [127:0] kb,
                               input logic [127:0] pa, input logic [127:0] pb);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            data_rdy = 2'b10;
            data_ina = ka[i];
            data_inb = kb[i];
        end
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            data_rdy = 2'b01;
            data_ina = pa[i];
            data_inb = pb[i];
        end
    endtask

    // Start, count edges to Done, check trigger width and result; optional load noise during RUN.
    task automatic run_enc(input string tag, input bit noisy);
        int edges;
        int trigs;
        logic [127:0] exp;
        logic [127:0] held;
        edges = 0;
        trigs = 0;
        @(negedge clk);
        data_rdy = 2'b11;
        while (!Done && edges < 100) begin
            @(negedge clk);
            edges++;
            if (Trig) trigs++;
            if (edges == 1) check_eq({tag, "_cipher_zero_in_run"}, cipher_out, 128'd0);
            if (noisy && edges >= 1 && edges < 60) begin
                data_rdy = 2'($urandom_range(1, 2));
                data_ina = 1'($urandom_range(0, 1));
                data_inb = 1'($urandom_range(0, 1));
            end else begin
                data_rdy = 2'b11;
            end
        end
        check_eq({tag, "_edges_to_done"}, 128'(edges), 128'd69);
        check_eq({tag, "_trig_cycles"}, 128'(trigs), 128'd1);
        exp = exp_q.pop_front();
        check_eq({tag, "_cipher"}, cipher_out, exp);
`ifdef SIMON2SHARE_SHARE_OUT_EN
        check_eq({tag, "_shares_xor"}, cipher_out_a ^ cipher_out_b, exp);
`endif
        held = cipher_out;
        repeat (3) @(negedge clk);
        check_eq({tag, "_done_held"}, 128'(Done), 128'd1);
        check_eq({tag, "_cipher_held"}, cipher_out, held);
        check_eq({tag, "_trig_no_restart"}, 128'(Trig), 128'd0);
    endtask

    initial begin
        logic [255:0] sa;
        logic [127:0] key2, pt2, mk, mp;

        rst_n    = 1'b0;
        data_rdy = 2'b00;
        data_ina = 1'b0;
        data_inb = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cipher", cipher_out, 128'd0);
        check_eq("rst_done", 128'(Done), 128'd0);
        check_eq("rst_trig", 128'(Trig), 128'd0);
        rst_n = 1'b1;

        // Standard vector with a random-looking mask.
        sa = STD_VEC ^ STD_SB;
        load_shares(sa[255:128], STD_SB[255:128], sa[127:0], STD_SB[127:0]);
        exp_q.push_back(STD_CT);
        run_enc("std", 1'b0);

        // Same vector, share B all zero.
        load_shares(STD_VEC[255:128], 128'd0, STD_VEC[127:0], 128'd0);
        exp_q.push_back(STD_CT);
        run_enc("b_zero", 1'b0);

        // Load commands during RUN must be ignored.
        load_shares(sa[255:128], STD_SB[255:128], sa[127:0], STD_SB[127:0]);
        exp_q.push_back(STD_CT);
        run_enc("noisy", 1'b1);

        // Abort mid-run with reset, then redo from scratch.
        load_shares(sa[255:128], STD_SB[255:128], sa[127:0], STD_SB[127:0]);
        @(negedge clk);
        data_rdy = 2'b11;
        repeat (31) @(negedge clk);
        rst_n    = 1'b0;
        data_rdy = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("abort_cipher", cipher_out, 128'd0);
        check_eq("abort_done", 128'(Done), 128'd0);
        check_eq("abort_trig", 128'(Trig), 128'd0);
        @(negedge clk);
        check_eq("abort_idle_no_trig", 128'(Trig), 128'd0);
        load_shares(sa[255:128], STD_SB[255:128], sa[127:0], STD_SB[127:0]);
        exp_q.push_back(STD_CT);
        run_enc("after_abort", 1'b0);

        // Leave DONE with a key-load command, then run a new vector.
        @(negedge clk);
        data_rdy = 2'b10;
        data_ina = 1'b1;
        data_inb = 1'b0;
        @(negedge clk);
        check_eq("exit_done_flag", 128'(Done), 128'd0);
        check_eq("exit_done_cipher", cipher_out, 128'd0);
        key2 = 128'h00112233445566778899aabbccddeeff;
        pt2  = 128'hdeadbeefcafef00d0123456789abcdef;
        mk   = {$urandom, $urandom, $urandom, $urandom};
        mp   = {$urandom, $urandom, $urandom, $urandom};
        load_shares(key2 ^ mk, mk, pt2 ^ mp, mp);
        exp_q.push_back(simon_ref(key2, pt2));
        run_enc("new_vec", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
